// File: rtl/snes_bus_settle.sv
// snes_bus_settle: synchronise a raw SNES bus, wait for it to settle, publish value and events
module snes_bus_settle #(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               SETTLE_CYCLES = 3,
  parameter logic [WIDTH-1:0] MATCH_ADDR    = WIDTH'('hFC),
  parameter logic [WIDTH-1:0] MATCH_MASK    = '1,
  parameter int               CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_sync,
  output logic             event_latch,
  output logic             match_hit,
  output logic             glitch,
  output logic             busy,
  output logic [CNT_W-1:0] event_count
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] CMAX = SW'(SETTLE_CYCLES - 1);
  typedef enum logic {IN_SYNC, UNSETTLED} state_t;
  state_t                              r_state, w_next;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;
  logic [WIDTH-1:0]                    r_prev, r_bus;
  logic [SW-1:0]                       r_cnt;
  logic [CNT_W-1:0]                    r_evcnt;
  logic                                r_ev, r_mh, r_gl;
  logic [WIDTH-1:0]                    w_s;
  logic                                w_diff, w_commit, w_new, w_match;
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_diff  = w_s != r_prev;
  assign w_new   = w_s != r_bus;
  assign w_match = ((w_s ^ MATCH_ADDR) & MATCH_MASK) == '0;
  // Synchroniser, stability counter and previous sample run regardless of enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus_in};
      r_prev <= w_s;
      r_cnt  <= w_diff ? '0 : (r_cnt == CMAX ? r_cnt : r_cnt + 1'b1);
    end
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    if (r_state == IN_SYNC) begin
      if (w_diff && enable) w_next = UNSETTLED;
    end else if (!enable) begin
      w_next = IN_SYNC;
    end else if (!w_diff && r_cnt == CMAX) begin
      w_next   = IN_SYNC;
      w_commit = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IN_SYNC;
      r_bus   <= '0;
      r_evcnt <= '0;
      r_ev    <= 1'b0;
      r_mh    <= 1'b0;
      r_gl    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ev    <= w_commit && w_new;
      r_mh    <= w_commit && w_new && w_match;
      r_gl    <= w_commit && !w_new;
      if (w_commit && w_new) begin
        r_bus   <= w_s;
        r_evcnt <= r_evcnt + 1'b1;
      end
    end
  assign bus_sync    = r_bus;
  assign event_latch = r_ev;
  assign match_hit   = r_mh;
  assign glitch      = r_gl;
  assign busy        = r_state == UNSETTLED;
  assign event_count = r_evcnt;
endmodule

// File: tb/tb_snes_bus_settle.sv
// tb_snes_bus_settle: random and directed stimulus against a sample-history reference model
module tb_snes_bus_settle;
  localparam int S  = 2;
  localparam int T  = 3;
  localparam int CW = 5;  // narrow counter so the wrap is reachable quickly
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [7:0]    bus_in = 8'h00;
  logic [7:0]    bus_sync;
  logic          event_latch, match_hit, glitch, busy;
  logic [CW-1:0] event_count;
  int            errors = 0, checks = 0;
  int            n_ev, n_gl, n_mh;
  logic [7:0]    hist [0:S+T];
  bit            m_open, m_ev, m_mh, m_gl;
  logic [7:0]    m_bus;
  logic [CW-1:0] m_cnt;

  snes_bus_settle #(.WIDTH(8), .SYNC_STAGES(S), .SETTLE_CYCLES(T), .MATCH_ADDR(8'hFC),
                    .MATCH_MASK(8'hFE), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus_in(bus_in), .bus_sync(bus_sync),
    .event_latch(event_latch), .match_hit(match_hit), .glitch(glitch), .busy(busy),
    .event_count(event_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= S + T; k++) hist[k] = 8'h00;
    m_open = 0; m_ev = 0; m_mh = 0; m_gl = 0; m_bus = 8'h00; m_cnt = '0;
  endtask

  // Commit when the value seen S samples ago has been held for T+1 consecutive samples
  task automatic model_edge();
    bit stable;
    logic [7:0] s;
    for (int k = S + T; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus_in;
    s = hist[S];
    stable = 1;
    for (int j = 1; j <= T; j++) if (hist[S+j] != s) stable = 0;
    m_ev = 0; m_mh = 0; m_gl = 0;
    if (!m_open) m_open = enable && (hist[S] != hist[S+1]);
    else if (!enable) m_open = 0;
    else if (stable) begin
      m_open = 0;
      if (s != m_bus) begin
        m_ev = 1;
        m_mh = ((s ^ 8'hFC) & 8'hFE) == 8'h00;
        m_bus = s;
        m_cnt = m_cnt + 1'b1;
      end else m_gl = 1;
    end
  endtask

  task automatic step(input logic [7:0] b, input logic en);
    bus_in = b;
    enable = en;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("bus_sync", bus_sync, m_bus);
    chk("event_latch", event_latch, m_ev);
    chk("match_hit", match_hit, m_mh);
    chk("glitch", glitch, m_gl);
    chk("busy", busy, m_open);
    chk("event_count", event_count, m_cnt);
    n_ev += int'(event_latch);
    n_gl += int'(glitch);
    n_mh += int'(match_hit);
  endtask

  task automatic hold(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b1);
  endtask

  initial begin
    logic [7:0] v, last;
    logic [5:0] busy_trace, ev_trace;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_bus_sync", bus_sync, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", event_count, '0);
    rst_n = 1'b1;
    // quiet bus after reset
    n_ev = 0; n_gl = 0; n_mh = 0;
    hold(8'h00, 50);
    chk("t1_events", n_ev, 0);
    chk("t1_glitches", n_gl, 0);
    // single change: busy from E+2 to E+5, event after E+5
    for (int i = 0; i < 6; i++) begin
      step(8'hA5, 1'b1);
      busy_trace[i] = busy;
      ev_trace[i] = event_latch;
    end
    chk("t2_busy_trace", busy_trace, 6'b011100);
    chk("t2_ev_trace", ev_trace, 6'b100000);
    hold(8'hA5, 3);
    chk("t2_bus_sync", bus_sync, 8'hA5);
    chk("t2_count", event_count, 1);
    // noisy bus then settle on 3C
    n_ev = 0; last = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      do v = 8'($urandom); while (v == last || v == 8'h3C);
      step(v, 1'b1);
      last = v;
    end
    hold(8'h3C, 10);
    chk("t3_events", n_ev, 1);
    chk("t3_bus_sync", bus_sync, 8'h3C);
    // excursion back to the settled value is a glitch
    n_ev = 0; n_gl = 0;
    hold(8'h55, 2);
    hold(8'h3C, 10);
    chk("t4_glitches", n_gl, 1);
    chk("t4_events", n_ev, 0);
    chk("t4_count", event_count, 2);
    // masked address match
    n_mh = 0; n_ev = 0;
    hold(8'hFD, 10);
    chk("t5_match_fd", n_mh, 1);
    hold(8'hFE, 10);
    chk("t5_match_fe", n_mh, 1);
    chk("t5_events", n_ev, 2);
    // enable dropped while busy
    n_ev = 0;
    hold(8'h11, 3);
    chk("t6_busy_before", busy, 1'b1);
    step(8'h11, 1'b0);
    chk("t6_busy_drop", busy, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h11, 1'b0);
    hold(8'h11, 6);
    chk("t6_no_event", n_ev, 0);
    chk("t6_bus_sync", bus_sync, 8'hFE);
    // reset while unsettled
    hold(8'h22, 3);
    chk("t6_busy_pre_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_bus_sync", bus_sync, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_count", event_count, '0);
    chk("arst_pulses", {event_latch, match_hit, glitch}, 3'b000);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // counter wrap
    for (int i = 0; i < 32; i++) begin
      hold(8'(i + 1), 6);
      if (i == 30) chk("wrap_pre", event_count, 31);
    end
    chk("wrap_zero", event_count, 0);
    // random segments with occasional enable drops
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? m_bus : 8'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 7)); k++)
        step(v, $urandom_range(0, 9) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
